// File: rtl/da_fir_pkg.sv
// Shared constants, derived widths and FSM state type for the distributed-arithmetic FIR.
// TAPS must equal GROUPS * GROUP_TAPS.
package da_fir_pkg;

    localparam int unsigned TAPS       = 64;
    localparam int unsigned GROUPS     = 8;
    localparam int unsigned GROUP_TAPS = 8;
    localparam int unsigned XW         = 16;
    localparam int unsigned CW         = 16;
    localparam int unsigned PW         = CW + 6;
    localparam int unsigned YW         = CW + 6 + XW;

    typedef enum logic {
        StIdle,
        StAcc
    } state_e;

endpackage

// File: rtl/da_lut.sv
// Combinational partial sum of one 8-tap group: adds each coefficient whose address bit is set.
// The output is wide enough for eight full-scale coefficients.
module da_lut
    import da_fir_pkg::*;
#(
    parameter int unsigned CW = da_fir_pkg::CW
) (
    input  logic [GROUP_TAPS-1:0] addr_i,
    input  logic signed [CW-1:0]  coef_i [GROUP_TAPS],
    output logic signed [CW+2:0]  sum_o
);

    always_comb begin
        sum_o = '0;
        for (int b = 0; b < GROUP_TAPS; b++) begin
            if (addr_i[b]) begin
                sum_o = sum_o + {{3{coef_i[b][CW-1]}}, coef_i[b]};
            end
        end
    end

endmodule

// File: rtl/da_accumulator.sv
// DA multiply-accumulate stage: programmable coefficient file, slice partial sum and
// MSB-first shift-accumulate producing one exact filter output per frame.
module da_accumulator
    import da_fir_pkg::*;
#(
    parameter int unsigned XW = da_fir_pkg::XW,
    parameter int unsigned CW = da_fir_pkg::CW,
    parameter int unsigned YW = CW + 6 + XW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_i,
    input  logic                 bit_en_i,
    input  logic [7:0]           a0_i,
    input  logic [7:0]           a1_i,
    input  logic [7:0]           a2_i,
    input  logic [7:0]           a3_i,
    input  logic [7:0]           a4_i,
    input  logic [7:0]           a5_i,
    input  logic [7:0]           a6_i,
    input  logic [7:0]           a7_i,
    input  logic                 coef_we_i,
    input  logic [5:0]           coef_addr_i,
    input  logic signed [CW-1:0] coef_data_i,
    output logic signed [YW-1:0] y_o,
    output logic                 y_valid_o,
    output logic                 busy_o
);

    localparam int unsigned LutW = CW + 3;
    localparam int unsigned SumW = CW + 6;
    localparam int unsigned CntW = $clog2(XW);
    localparam logic [CntW-1:0] CntTop = CntW'(XW - 1);

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic signed [YW-1:0]  acc_q;
    logic signed [YW-1:0]  y_q;
    logic                  y_valid_q;
    logic signed [CW-1:0]  h_q [TAPS];

    logic [7:0]            addr     [GROUPS];
    logic signed [CW-1:0]  grp_coef [GROUPS][GROUP_TAPS];
    logic signed [LutW-1:0] lut_sum [GROUPS];
    logic signed [SumW-1:0] p;
    logic signed [YW-1:0]  p_ext;
    logic signed [YW-1:0]  p_neg;
    logic signed [YW-1:0]  acc_shift;

    assign addr[0] = a0_i;
    assign addr[1] = a1_i;
    assign addr[2] = a2_i;
    assign addr[3] = a3_i;
    assign addr[4] = a4_i;
    assign addr[5] = a5_i;
    assign addr[6] = a6_i;
    assign addr[7] = a7_i;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar b = 0; b < GROUP_TAPS; b++) begin : g_tap
            assign grp_coef[g][b] = h_q[g*GROUP_TAPS+b];
        end

        da_lut #(
            .CW (CW)
        ) u_lut (
            .addr_i (addr[g]),
            .coef_i (grp_coef[g]),
            .sum_o  (lut_sum[g])
        );
    end

    always_comb begin
        p = '0;
        for (int g = 0; g < GROUPS; g++) begin
            p = p + {{(SumW-LutW){lut_sum[g][LutW-1]}}, lut_sum[g]};
        end
    end

    assign p_ext     = {{(YW-SumW){p[SumW-1]}}, p};
    // The MSB slice carries negative weight in two's complement.
    assign p_neg     = -p_ext;
    assign acc_shift = (acc_q <<< 1) + p_ext;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= CntTop;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                h_q[k] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            if (coef_we_i && (state_q == StIdle)) begin
                h_q[coef_addr_i] <= coef_data_i;
            end
            case (state_q)
                StIdle: begin
                    if (frame_i) begin
                        state_q <= StAcc;
                        cnt_q   <= CntTop;
                    end
                end
                StAcc: begin
                    if (bit_en_i && (cnt_q == '0)) begin
                        // Last slice completes even if a new frame arrives on this edge.
                        y_q       <= acc_shift;
                        y_valid_q <= 1'b1;
                        acc_q     <= acc_shift;
                        cnt_q     <= CntTop;
                        if (!frame_i) begin
                            state_q <= StIdle;
                        end
                    end else if (frame_i) begin
                        acc_q <= '0;
                        cnt_q <= CntTop;
                    end else if (bit_en_i) begin
                        acc_q <= (cnt_q == CntTop) ? p_neg : acc_shift;
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign y_o       = y_q;
    assign y_valid_o = y_valid_q;
    assign busy_o    = (state_q == StAcc);

endmodule

// File: tb/tb_da_accumulator.sv
// Directed and randomized bench for da_accumulator against a dot-product reference model.
module tb_da_accumulator;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               frame = 1'b0;
    logic               bit_en = 1'b0;
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic [7:0]         a [8];
    logic signed [37:0] y;
    logic               y_valid;
    logic               busy;

    int total = 0;
    int bad = 0;

    logic [15:0] hm [64];
    logic [15:0] xs [64];

    always #5 clk = ~clk;

    da_accumulator dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_i     (frame),
        .bit_en_i    (bit_en),
        .a0_i        (a[0]),
        .a1_i        (a[1]),
        .a2_i        (a[2]),
        .a3_i        (a[3]),
        .a4_i        (a[4]),
        .a5_i        (a[5]),
        .a6_i        (a[6]),
        .a7_i        (a[7]),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .y_o         (y),
        .y_valid_o   (y_valid),
        .busy_o      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Exact dot product of the modelled coefficients and samples.
    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < 64; k++) begin
            s += longint'($signed(hm[k])) * longint'($signed(xs[k]));
        end
        return s;
    endfunction

    task automatic rand_a;
        for (int g = 0; g < 8; g++) a[g] = 8'($urandom);
    endtask

    task automatic drive_slice(input int s);
        for (int g = 0; g < 8; g++)
            for (int b = 0; b < 8; b++) a[g][b] = xs[8*g+b][s];
    endtask

    task automatic consume(input int s);
        drive_slice(s);
        bit_en = 1'b1;
        tick;
    endtask

    task automatic write_h(input int k, input logic [15:0] v, input bit accepted);
        coef_we   = 1'b1;
        coef_addr = 6'(k);
        coef_data = v;
        tick;
        coef_we = 1'b0;
        if (accepted) hm[k] = v;
    endtask

    task automatic set_x_all(input logic [15:0] v);
        for (int k = 0; k < 64; k++) xs[k] = v;
    endtask

    task automatic rand_x;
        for (int k = 0; k < 64; k++) xs[k] = 16'($urandom);
    endtask

    task automatic rand_h;
        for (int k = 0; k < 64; k++) write_h(k, 16'($urandom), 1'b1);
    endtask

    // Pulse frame (with garbage slice and random bit_en, which must not be consumed),
    // then stream 16 slices MSB first with an optional stall before slice stall_at.
    task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                             input longint exp);
        frame  = 1'b1;
        bit_en = 1'($urandom_range(0, 1));
        rand_a;
        tick;
        frame = 1'b0;
        chk({tag, ".busy_rise"}, busy, 1);
        for (int s = 15; s >= 0; s--) begin
            if (s == stall_at) begin
                for (int i = 0; i < stall_len; i++) begin
                    bit_en = 1'b0;
                    rand_a;
                    tick;
                    chk({tag, ".stall_valid"}, y_valid, 0);
                end
            end
            consume(s);
            if (s > 0) chk({tag, ".early_valid"}, y_valid, 0);
        end
        bit_en = 1'b0;
        chk({tag, ".valid"}, y_valid, 1);
        chk({tag, ".y"}, y, exp);
        tick;
        chk({tag, ".valid_pulse"}, y_valid, 0);
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".y_hold"}, y, exp);
    endtask

    initial begin
        longint exp_a;
        longint exp_b;
        for (int g = 0; g < 8; g++) a[g] = '0;
        for (int k = 0; k < 64; k++) hm[k] = '0;
        set_x_all(16'h0000);

        resetn = 1'b0;
        tick;
        tick;
        chk("rst.y", y, 0);
        chk("rst.valid", y_valid, 0);
        chk("rst.busy", busy, 0);
        resetn = 1'b1;

        set_x_all(16'hFFFF);
        run_frame("zero_h", -1, 0, 0);

        write_h(0, 16'h0001, 1'b1);
        set_x_all(16'h0000);
        xs[0] = 16'h0003;
        run_frame("tap0", -1, 0, 3);

        xs[0] = 16'h8000;
        run_frame("sign0", -1, 0, -32768);

        write_h(0, 16'h0000, 1'b1);
        write_h(63, 16'hFFFE, 1'b1);
        set_x_all(16'h0000);
        xs[63] = 16'h7FFF;
        run_frame("sign63", -1, 0, -65534);

        for (int k = 0; k < 64; k++) write_h(k, 16'h7FFF, 1'b1);
        set_x_all(16'h8000);
        run_frame("full", -1, 0, -64'sd68717379584);

        rand_h;
        rand_x;
        run_frame("stall3", 8, 3, model_y());

        for (int r = 0; r < 4; r++) begin
            rand_x;
            run_frame("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      model_y());
        end

        // Abort: a second frame after 5 slices discards the first.
        rand_x;
        frame = 1'b1;
        tick;
        frame = 1'b0;
        for (int s = 15; s >= 11; s--) begin
            consume(s);
            chk("abort.first_valid", y_valid, 0);
        end
        rand_x;
        run_frame("abort2", -1, 0, model_y());

        // Overlap: new frame on the last-slice edge; both report.
        rand_x;
        exp_a = model_y();
        frame = 1'b1;
        tick;
        frame = 1'b0;
        for (int s = 15; s >= 1; s--) consume(s);
        drive_slice(0);
        bit_en = 1'b1;
        frame  = 1'b1;
        tick;
        frame = 1'b0;
        chk("overlap.valid_a", y_valid, 1);
        chk("overlap.y_a", y, exp_a);
        chk("overlap.busy", busy, 1);
        rand_x;
        exp_b = model_y();
        for (int s = 15; s >= 0; s--) begin
            consume(s);
            if (s > 0) chk("overlap.early_b", y_valid, 0);
        end
        bit_en = 1'b0;
        chk("overlap.valid_b", y_valid, 1);
        chk("overlap.y_b", y, exp_b);
        tick;
        chk("overlap.busy_fall", busy, 0);

        // Coefficient write while busy is dropped.
        rand_x;
        exp_a = model_y();
        frame = 1'b1;
        tick;
        frame = 1'b0;
        for (int s = 15; s >= 8; s--) consume(s);
        coef_we   = 1'b1;
        coef_addr = 6'd5;
        coef_data = ~hm[5];
        consume(7);
        coef_we = 1'b0;
        for (int s = 6; s >= 0; s--) consume(s);
        bit_en = 1'b0;
        chk("lock.valid", y_valid, 1);
        chk("lock.y", y, exp_a);
        tick;
        xs[5] = 16'h7FFF;
        run_frame("lock_next", -1, 0, model_y());

        // Reset mid-frame clears everything, including coefficients.
        frame = 1'b1;
        tick;
        frame = 1'b0;
        for (int s = 15; s >= 13; s--) consume(s);
        bit_en = 1'b0;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk("midrst.busy", busy, 0);
        chk("midrst.y", y, 0);
        chk("midrst.valid", y_valid, 0);
        for (int k = 0; k < 64; k++) hm[k] = '0;
        write_h(1, 16'h0007, 1'b1);
        rand_x;
        run_frame("post_rst", -1, 0, model_y());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
